// File: rtl/commit_tracer_pkg.sv
// Shared definitions for the commit tracer: PC width, FSM state encodings,
// FIFO entry width, and the FSM state type.
// Macro COMMIT_TRACE_HALT_EN (set at build time) enables the halt-on-error
// freeze; it is consumed by commit_tracer.sv.
`ifndef COMMIT_TRACER_DEFS
`define COMMIT_TRACER_DEFS
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`define TRACE_ST_IDLE 2'd0
`define TRACE_ST_RUN  2'd1
`define TRACE_ST_ERR  2'd2
// Entry layout: {pc, npc, seq}
`define TRACE_ENTRY_W(cnt_w) (2*`PC_WIDTH+(cnt_w))
`endif

package commit_tracer_pkg;
  localparam int PC_W = `PC_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = `TRACE_ST_IDLE,
    S_RUN  = `TRACE_ST_RUN,
    S_ERR  = `TRACE_ST_ERR
  } trace_st_e;
endpackage

// File: rtl/commit_tracer_fifo.sv
// Generic show-ahead synchronous FIFO. dout is the head entry read
// combinationally from registered storage. Push while full is accepted only
// when a pop frees a slot in the same cycle; pop while empty is ignored.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally; occupancy tracked separately.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/commit_tracer.sv
// Commit-side tracer: buffers {pc, npc, seq} of each retired instruction in a
// show-ahead FIFO and checks that every commit PC matches the previous
// commit's predicted next-PC.
// Optional build macro COMMIT_TRACE_HALT_EN: on the first continuity error,
// raise halt_o and freeze the FIFO/commit counter for post-mortem reads.
module commit_tracer
  import commit_tracer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     commit_i,
  input  logic [`PC_WIDTH-1:0]     commit_pc_i,
  input  logic [`PC_WIDTH-1:0]     commit_pre_pc_i,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output logic [`PC_WIDTH-1:0]     rd_pc_o,
  output logic [`PC_WIDTH-1:0]     rd_npc_o,
  output logic [CNT_W-1:0]         rd_seq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic [CNT_W-1:0]         commit_cnt_o,
  output logic                     mismatch_o,
  output logic [`PC_WIDTH-1:0]     mismatch_pc_o,
  output logic                     halt_o
);
  localparam int EW = `TRACE_ENTRY_W(CNT_W);

  trace_st_e            state, state_nxt;
  logic [PC_W-1:0]      expected_pc, expected_nxt;
  logic                 mm_set;
  logic                 halt_blk;
  logic                 push_req;
  logic                 drop;
  logic                 empty;
  logic [EW-1:0]        fifo_din, fifo_dout;

`ifdef COMMIT_TRACE_HALT_EN
  assign halt_blk = halt_o;

  // Halt latches on the transition into the error state.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst)        halt_o <= 1'b0;
    else if (mm_set) halt_o <= 1'b1;
  end
`else
  assign halt_blk = 1'b0;
  assign halt_o   = 1'b0;
`endif

  // Once halted, commits are neither buffered nor counted.
  assign push_req = commit_i & ~halt_blk;
  // Full with no pop in the same cycle: the commit is lost.
  assign drop     = push_req & full_o & ~rd_en_i;
  assign fifo_din = {commit_pc_i, commit_pre_pc_i, commit_cnt_o};

  trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst   (rst),
    .push  (push_req),
    .pop   (rd_en_i),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (count_o),
    .full  (full_o),
    .empty (empty)
  );

  assign rd_valid_o = ~empty;
  assign {rd_pc_o, rd_npc_o, rd_seq_o} = fifo_dout;

  // Commit counter (wraps) and saturating drop counter with sticky overflow.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      commit_cnt_o <= '0;
      drop_cnt_o   <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (push_req) commit_cnt_o <= commit_cnt_o + 1'b1;
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

  // Continuity FSM state and expected next-PC registers.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      expected_pc <= '0;
    end else begin
      state       <= state_nxt;
      expected_pc <= expected_nxt;
    end
  end

  // Next-state: first commit seeds the expectation, later ones are checked.
  always_comb begin
    state_nxt    = state;
    expected_nxt = expected_pc;
    mm_set       = 1'b0;
    case (state)
      S_IDLE: if (commit_i) begin
        expected_nxt = commit_pre_pc_i;
        state_nxt    = S_RUN;
      end
      S_RUN: if (commit_i) begin
        if (commit_pc_i == expected_pc) begin
          expected_nxt = commit_pre_pc_i;
        end else begin
          mm_set    = 1'b1;
          state_nxt = S_ERR;
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sticky mismatch flag; the PC is captured only on entry to S_ERR.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      mismatch_o    <= 1'b0;
      mismatch_pc_o <= '0;
    end else if (mm_set) begin
      mismatch_o    <= 1'b1;
      mismatch_pc_o <= commit_pc_i;
    end
  end
endmodule

// File: tb/tb_commit_tracer.sv
// Directed self-checking bench for commit_tracer (DEPTH=8, CNT_W=32).
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
module tb_commit_tracer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;
  localparam int PW    = `PC_WIDTH;

  logic             clk_i = 1'b0;
  logic             rst   = 1'b0;
  logic             commit_i = 1'b0;
  logic [PW-1:0]    commit_pc_i = '0;
  logic [PW-1:0]    commit_pre_pc_i = '0;
  logic             rd_en_i = 1'b0;
  logic             rd_valid_o;
  logic [PW-1:0]    rd_pc_o, rd_npc_o;
  logic [CNT_W-1:0] rd_seq_o;
  logic [$clog2(DEPTH):0] count_o;
  logic             full_o, overflow_o;
  logic [CNT_W-1:0] drop_cnt_o, commit_cnt_o;
  logic             mismatch_o;
  logic [PW-1:0]    mismatch_pc_o;
  logic             halt_o;

  int n_chk  = 0;
  int n_pass = 0;

  commit_tracer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst(rst), .commit_i(commit_i), .commit_pc_i(commit_pc_i),
    .commit_pre_pc_i(commit_pre_pc_i), .rd_en_i(rd_en_i),
    .rd_valid_o(rd_valid_o), .rd_pc_o(rd_pc_o), .rd_npc_o(rd_npc_o),
    .rd_seq_o(rd_seq_o), .count_o(count_o), .full_o(full_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o),
    .commit_cnt_o(commit_cnt_o), .mismatch_o(mismatch_o),
    .mismatch_pc_o(mismatch_pc_o), .halt_o(halt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic cmt(input logic [PW-1:0] pc, input logic [PW-1:0] npc, input logic pop);
    commit_i = 1'b1; commit_pc_i = pc; commit_pre_pc_i = npc; rd_en_i = pop;
    tick();
    commit_i = 1'b0; rd_en_i = 1'b0;
  endtask

  task automatic pop1();
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    int seqs [8];
    @(negedge clk_i);
    // Reset state (async, clock has not advanced any state)
    chk("rst_valid",  rd_valid_o, 0);
    chk("rst_count",  count_o, 0);
    chk("rst_full",   full_o, 0);
    chk("rst_ovf",    overflow_o, 0);
    chk("rst_ccnt",   commit_cnt_o, 0);
    chk("rst_mm",     mismatch_o, 0);
    chk("rst_halt",   halt_o, 0);
    rst = 1'b1;
    tick();

    // Empty pop is ignored
    pop1();
    chk("epop_count", count_o, 0);
    chk("epop_valid", rd_valid_o, 0);

    // Sequential commits then drain
    cmt(32'h00, 32'h04, 0);
    chk("seq_vis", rd_valid_o, 1);
    cmt(32'h04, 32'h08, 0);
    cmt(32'h08, 32'h0C, 0);
    chk("seq_count", count_o, 3);
    chk("seq_ccnt",  commit_cnt_o, 3);
    for (int i = 0; i < 3; i++) begin
      chk("seq_pc",  rd_pc_o,  4*i);
      chk("seq_npc", rd_npc_o, 4*i + 4);
      chk("seq_seq", rd_seq_o, i);
      pop1();
    end
    chk("seq_empty", rd_valid_o, 0);
    chk("seq_mm",    mismatch_o, 0);

    // Pop while empty together with a push: push only
    cmt(32'h0C, 32'h10, 1);
    chk("ep_count", count_o, 1);
    chk("ep_valid", rd_valid_o, 1);
    chk("ep_seq",   rd_seq_o, 3);
    chk("ep_mm",    mismatch_o, 0);

    // Overflow: 10 commits into 8 entries
    rst_pulse();
    chk("mrst_count", count_o, 0);
    for (int i = 0; i < 10; i++) cmt(32'h100 + 4*i, 32'h104 + 4*i, 0);
    chk("ovf_count", count_o, 8);
    chk("ovf_full",  full_o, 1);
    chk("ovf_flag",  overflow_o, 1);
    chk("ovf_drop",  drop_cnt_o, 2);
    chk("ovf_ccnt",  commit_cnt_o, 10);
    chk("ovf_head",  rd_seq_o, 0);

    // Push+pop while full: no drop, new entry goes to the tail
    cmt(32'h128, 32'h12C, 1);
    chk("fpp_count", count_o, 8);
    chk("fpp_drop",  drop_cnt_o, 2);
    chk("fpp_ccnt",  commit_cnt_o, 11);
    seqs = '{1, 2, 3, 4, 5, 6, 7, 10};
    for (int i = 0; i < 8; i++) begin
      chk("fpp_seq", rd_seq_o, seqs[i]);
      chk("fpp_pc",  rd_pc_o, (seqs[i] == 10) ? 32'h128 : 32'h100 + 4*seqs[i]);
      pop1();
    end
    chk("fpp_empty", rd_valid_o, 0);
    chk("fpp_mm",    mismatch_o, 0);

    // Continuity error
    rst_pulse();
    chk("mrst_ovf",  overflow_o, 0);
    chk("mrst_drop", drop_cnt_o, 0);
    cmt(32'h10, 32'h14, 0);
    chk("ce_ok", mismatch_o, 0);
    cmt(32'h20, 32'h24, 0);
    chk("ce_mm",   mismatch_o, 1);
    chk("ce_mmpc", mismatch_pc_o, 32'h20);
    cmt(32'h40, 32'h44, 0);
    chk("ce_mmpc2", mismatch_pc_o, 32'h20);
`ifdef COMMIT_TRACE_HALT_EN
    chk("ce_halt",  halt_o, 1);
    chk("ce_count", count_o, 2);
    chk("ce_ccnt",  commit_cnt_o, 2);
`else
    chk("ce_halt",  halt_o, 0);
    chk("ce_count", count_o, 3);
    chk("ce_ccnt",  commit_cnt_o, 3);
`endif

    // Mid-stream reset clears flags; first commit afterwards is not flagged
    rst_pulse();
    chk("r2_count", count_o, 0);
    chk("r2_mm",    mismatch_o, 0);
    chk("r2_mmpc",  mismatch_pc_o, 0);
    chk("r2_halt",  halt_o, 0);
    cmt(32'h500, 32'h504, 0);
    chk("r2_first", mismatch_o, 0);
    chk("r2_cnt1",  count_o, 1);
    chk("r2_seq",   rd_seq_o, 0);
    chk("r2_pc",    rd_pc_o, 32'h500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/commit_tracer.md
Name: commit_tracer

Overview:
Commit-side consumer that sits directly downstream of the CPU top's commit interface (`commit`, `commit_pc`, `commit_pre_pc`). It buffers every retired instruction's PC and its predicted next-PC in a show-ahead FIFO for a debug/difftest reader. It also checks control-flow continuity: each committed PC must equal the previous commit's predicted next-PC. Errors are reported through sticky flags and a small state machine.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
CNT_W, 32, width of the retired-instruction and drop counters

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
commit_i  in  1  one instruction retires this cycle
commit_pc_i  in  `PC_WIDTH  PC of the retiring instruction
commit_pre_pc_i  in  `PC_WIDTH  next-PC recorded for the retiring instruction
rd_en_i  in  1  reader pops the head entry
rd_valid_o  out  1  FIFO non-empty; head entry valid
rd_pc_o  out  `PC_WIDTH  head entry PC
rd_npc_o  out  `PC_WIDTH  head entry next-PC
rd_seq_o  out  CNT_W  head entry sequence number (commit index)
count_o  out  $clog2(DEPTH)+1  occupancy
full_o  out  1  occupancy == DEPTH
overflow_o  out  1  sticky: a commit was dropped
drop_cnt_o  out  CNT_W  number of dropped commits
commit_cnt_o  out  CNT_W  total commits seen
mismatch_o  out  1  sticky continuity error
mismatch_pc_o  out  `PC_WIDTH  commit_pc_i of the first offending commit
halt_o  out  1  freeze request (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): pointers, count, and all counters clear to 0. All sticky flags, mismatch_pc_o, and halt_o go to 0. FSM enters S_IDLE. rd_valid_o=0, full_o=0. FIFO storage is not cleared.
- Push: on each commit_i=1, write {commit_pc_i, commit_pre_pc_i, commit_cnt_o}. commit_cnt_o increments by 1 every commit, including dropped ones, and wraps at 2^CNT_W.
- Pop: rd_en_i with rd_valid_o=1 advances the head. rd_en_i while empty is ignored and causes no underflow.
- Show-ahead read: rd_* reflect the head combinationally from registered storage. A push into an empty FIFO is visible on the next cycle.
- Full handling:
  - Push+pop in the same cycle while full: both succeed; count unchanged.
  - Push with no pop while full: entry dropped, overflow_o set, drop_cnt_o incremented. drop_cnt_o saturates at all-ones.
- Push+pop while empty: push only; pop ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. count_o is tracked separately.
- FSM:
  - S_IDLE: no commit yet. On commit, load expected_pc = commit_pre_pc_i; go to S_RUN.
  - S_RUN: on commit, compare commit_pc_i with expected_pc.
    - Equal: reload expected_pc = commit_pre_pc_i.
    - Not equal: set mismatch_o, capture mismatch_pc_o, go to S_ERR.
  - S_ERR: terminal until reset. Pushes and counting continue; mismatch_pc_o is not recaptured.
- Reset asserted mid-operation discards all buffered entries. The first commit after reset is never flagged.

Optional Feature:
COMMIT_TRACE_HALT_EN
- Defined: entry to S_ERR sets halt_o=1 (registered, one cycle after the offending commit). The offending commit is still pushed, if there is space. From the cycle after entry, further commits are neither pushed nor counted, so the FIFO freezes for post-mortem. Pops remain allowed.
- Undefined: halt_o is tied to 0 and S_ERR does not block pushes.

Decomposition:
- Shared include (define.v): `PC_WIDTH (existing), plus TRACE_ST_IDLE/RUN/ERR state encodings (2 bits) and a TRACE_ENTRY_W width macro.
- Sub-module trace_fifo: generic show-ahead synchronous FIFO with parameters WIDTH and DEPTH. Ports: push, pop, din, dout, count, full, empty, same clk_i/rst convention.
- commit_tracer adds the FSM, counters, drop logic, and halt logic around trace_fifo.

Test Plan:
- Sequential commits: PCs 0x00, 0x04, 0x08, each with npc = pc+4; then pop 3 → reads (0x00,0x04,seq 0), (0x04,0x08,1), (0x08,0x0C,2); mismatch_o=0.
- Continuity error: commit (0x10, npc 0x14), then commit pc 0x20 → mismatch_o=1 and mismatch_pc_o=0x20 next cycle. A later bad commit (0x40) leaves mismatch_pc_o at 0x20.
- Overflow, DEPTH=8: 10 commits with no pops → count_o=8, full_o=1, overflow_o=1, drop_cnt_o=2, commit_cnt_o=10. Head seq is 0; seq 8 and 9 are absent.
- Full with push+pop in the same cycle: count_o stays 8, no drop; the new entry later appears at the tail with the correct seq.
- Empty pop plus simultaneous push: count_o=1, rd_valid_o=1 next cycle. Mid-stream rst pulse → count_o=0, flags clear, next commit not flagged.
- Build with COMMIT_TRACE_HALT_EN: after a mismatch, halt_o=1 and subsequent commits do not change count_o or commit_cnt_o. Build without it: halt_o stays 0 and pushes continue.
